// File: rtl/song_select_ctrl.sv
// Song selection front end for the song-name display driver: it debounces the
// panel buttons and runs the browse/play state machine over four stored songs.

module song_select_debounce #(
  parameter int DEB_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_ev
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_ev;
  logic [CNT_W-1:0] r_count;

  // Accept a new level only after it has disagreed with the stable level for
  // DEB_CYCLES consecutive synchronized samples; only rising levels emit an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_ev     <= 1'b0;
      r_count  <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_ev    <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_count <= '0;
      end else if (r_count == CNT_LAST) begin
        r_stable <= r_sync2;
        r_count  <= '0;
        r_ev     <= r_sync2;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_ev = r_ev;

endmodule

module song_select_ctrl #(
  parameter int DEB_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_play,
  input  logic       play_done,
  output logic [4:0] song,
  output logic       play_start,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic [1:0] r_idx;
  logic [1:0] w_idxNext;
  logic       w_playStartNext;
  logic       w_busyNext;
  logic [4:0] w_songNext;
  logic       w_evMode;
  logic       w_evNext;
  logic       w_evPrev;
  logic       w_evPlay;

  song_select_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debMode (
    .clk(clk), .rst(rst), .i_btn(btn_mode), .o_ev(w_evMode));
  song_select_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debNext (
    .clk(clk), .rst(rst), .i_btn(btn_next), .o_ev(w_evNext));
  song_select_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debPrev (
    .clk(clk), .rst(rst), .i_btn(btn_prev), .o_ev(w_evPrev));
  song_select_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debPlay (
    .clk(clk), .rst(rst), .i_btn(btn_play), .o_ev(w_evPlay));

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      song       <= 5'b00000;
      play_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_idx      <= w_idxNext;
      song       <= w_songNext;
      play_start <= w_playStartNext;
      busy       <= w_busyNext;
    end
  end

  // The if/else chain encodes the event priority mode > play > next > prev.
  always_comb begin
    w_stateNext     = r_state;
    w_idxNext       = r_idx;
    w_playStartNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_evMode) w_stateNext = SELECT;
      end
      SELECT: begin
        if (w_evMode) begin
          w_stateNext = IDLE;
        end else if (w_evPlay) begin
          w_stateNext     = PLAY;
          w_playStartNext = 1'b1;
        end else if (w_evNext) begin
          w_idxNext = r_idx + 2'd1;
        end else if (w_evPrev) begin
          w_idxNext = r_idx - 2'd1;
        end
      end
      PLAY: begin
        if (play_done) w_stateNext = SELECT;
      end
      default: w_stateNext = IDLE;
    endcase

    w_songNext = 5'b00000;
    if (w_stateNext != IDLE) w_songNext = {1'b1, 4'b0001 << w_idxNext};
    w_busyNext = (w_stateNext == PLAY);
  end

endmodule
